// File: rtl/lcd_fb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lcd_fb_arbiter: shares a single-port framebuffer RAM between LCD scanout    |
// | prefetch (priority) and a pixel writer; feeds 16-bit pixels aligned to DE.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module lcd_fb_arbiter #(
  parameter int H_ACTIVE   = 480,
  parameter int V_ACTIVE   = 272,
  parameter int ADDR_W     = 15,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              PixelClk,
  input  logic              nRST,
  input  logic              frame_start,
  input  logic              de,
  output logic [15:0]       pix_data,
  output logic              underflow,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [63:0]       wr_data,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [63:0]       ram_wdata,
  input  logic [63:0]       ram_rdata
);

  localparam int c_ptr_w = $clog2(FIFO_DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam logic [ADDR_W-1:0]  c_last_word = ADDR_W'(H_ACTIVE * V_ACTIVE / 4 - 1);
  localparam logic [c_cnt_w-1:0] c_depth     = c_cnt_w'(FIFO_DEPTH);

  logic [63:0]        r_fifo [FIFO_DEPTH];
  logic [c_ptr_w-1:0] r_wptr;
  logic [c_ptr_w-1:0] r_rptr;
  logic [c_cnt_w-1:0] r_count;
  logic               r_inflight;
  logic [ADDR_W-1:0]  r_rd_ptr;
  logic [1:0]         r_lane;
  logic               r_frame_done;
  logic               r_active;
  logic [15:0]        r_pix_data;
  logic               r_underflow;

  logic        w_space;
  logic        w_scan_req;
  logic        w_wr_acc;
  logic        w_push;
  logic        w_pop;
  logic        w_empty;
  logic [63:0] w_head;

  // Counting the in-flight read as occupied space keeps the FIFO from overflowing.
  assign w_space    = (r_count + c_cnt_w'(r_inflight)) < c_depth;
  assign w_scan_req = !r_frame_done && w_space && !frame_start;
  assign wr_ready   = r_active && !w_scan_req && !frame_start;
  assign w_wr_acc   = wr_valid && wr_ready;
  assign w_empty    = (r_count == '0);
  assign w_push     = r_inflight && !frame_start;
  assign w_pop      = de && !frame_start && !w_empty && (r_lane == 2'd3);
  assign w_head     = r_fifo[r_rptr];

  assign pix_data  = r_pix_data;
  assign underflow = r_underflow;

  always_comb begin
    ram_en    = w_scan_req || w_wr_acc;
    ram_we    = !w_scan_req && w_wr_acc;
    ram_addr  = '0;
    ram_wdata = '0;
    if (w_scan_req) begin
      ram_addr = r_rd_ptr;
    end else if (w_wr_acc) begin
      ram_addr  = wr_addr;
      ram_wdata = wr_data;
    end
  end

  always_ff @(posedge PixelClk) begin
    if (w_push) begin
      r_fifo[r_wptr] <= ram_rdata;
    end
  end

  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      r_active     <= 1'b0;
      r_frame_done <= 1'b1;
      r_rd_ptr     <= '0;
      r_inflight   <= 1'b0;
      r_count      <= '0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_lane       <= 2'd0;
      r_pix_data   <= 16'd0;
      r_underflow  <= 1'b0;
    end else begin
      r_active   <= 1'b1;
      // A read outstanding across frame_start is dropped by gating w_push.
      r_inflight <= w_scan_req;
      if (frame_start) begin
        r_frame_done <= 1'b0;
        r_rd_ptr     <= '0;
        r_count      <= '0;
        r_wptr       <= '0;
        r_rptr       <= '0;
        r_lane       <= 2'd0;
      end else begin
        if (w_scan_req) begin
          if (r_rd_ptr == c_last_word) begin
            r_frame_done <= 1'b1;
          end else begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
          end
        end
        if (w_push) begin
          r_wptr <= r_wptr + 1'b1;
        end
        if (w_pop) begin
          r_rptr <= r_rptr + 1'b1;
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
        if (de && !w_empty) begin
          r_lane <= r_lane + 2'd1;
        end
      end

      if (de && !frame_start && !w_empty) begin
        r_pix_data <= w_head[{r_lane, 4'b0000} +: 16];
      end else begin
        r_pix_data <= 16'd0;
      end
      if (de && (frame_start || w_empty)) begin
        r_underflow <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lcd_fb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_lcd_fb_arbiter: directed bench with a pixel scoreboard and a RAM model.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_lcd_fb_arbiter;

  localparam int H    = 480;
  localparam int V    = 8;
  localparam int AW   = 15;
  localparam int LAST = H * V / 4 - 1;
  localparam logic [AW-1:0] WBASE = 15'd16384;

  logic          clk = 1'b0;
  logic          nrst;
  logic          frame_start;
  logic          de;
  logic [15:0]   pix_data;
  logic          underflow;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [63:0]   wr_data;
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [63:0]   ram_wdata;
  logic [63:0]   ram_rdata;

  logic          init_mem;
  logic          poke_en;
  logic [63:0]   mem [0:(1<<AW)-1];

  logic [15:0]   exp_q [$];
  bit            de_s;
  int            n_cmp = 0;
  int            n_err = 0;
  int            rd_cnt = 0;
  int            wr_cnt = 0;
  int            nw = 0;
  logic [AW-1:0] last_rd = '0;

  always #5 clk = ~clk;

  lcd_fb_arbiter #(
    .H_ACTIVE  (H),
    .V_ACTIVE  (V),
    .ADDR_W    (AW),
    .FIFO_DEPTH(4)
  ) dut (
    .PixelClk   (clk),
    .nRST       (nrst),
    .frame_start(frame_start),
    .de         (de),
    .pix_data   (pix_data),
    .underflow  (underflow),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .ram_en     (ram_en),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  // Single-port RAM with one-cycle read latency.
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 1024; i++) mem[i] <= {4{16'(i)}};
    end else begin
      if (ram_en && ram_we) mem[ram_addr] <= ram_wdata;
      if (poke_en) begin
        mem[0] <= {4{16'h5555}};
        mem[1] <= {4{16'h6666}};
      end
    end
    if (ram_en && !ram_we) ram_rdata <= mem[ram_addr];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic to_neg;
    @(negedge clk);
    de_s = de;
    if (ram_en && !ram_we) begin
      rd_cnt++;
      last_rd = ram_addr;
      check("rd_excl_wr_ready", wr_ready, 0);
    end
    if (ram_en && ram_we) wr_cnt++;
  endtask

  task automatic to_pos;
    @(posedge clk);
    #1;
    if (de_s) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $error("FAIL pix_sb: observed %0h expected <no entry>", pix_data);
      end else begin
        check("pix", pix_data, exp_q.pop_front());
      end
    end
  endtask

  task automatic cyc;
    to_neg();
    to_pos();
  endtask

  task automatic next_write;
    nw++;
    wr_addr = WBASE + AW'(nw);
    wr_data = {48'hBEEF_0000_0000, 16'(nw)};
  endtask

  task automatic line(input int p0, input bit wr);
    bit acc;
    for (int i = 0; i < H; i++) begin
      de       = 1'b1;
      wr_valid = wr;
      exp_q.push_back(16'((p0 + i) / 4));
      to_neg();
      acc = wr_valid && wr_ready;
      if (wr) begin
        check("wr_slot_used", ram_en, 1);
        check("wr_we_is_ready", ram_we, wr_ready);
      end
      to_pos();
      if (acc) next_write();
    end
    de       = 1'b0;
    wr_valid = 1'b0;
  endtask

  initial begin
    int wr_before;
    nrst = 1'b0; frame_start = 1'b0; de = 1'b0; wr_valid = 1'b0;
    wr_addr = WBASE; wr_data = {48'hBEEF_0000_0000, 16'd0};
    init_mem = 1'b0; poke_en = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_pix_data", pix_data, 0);
    check("rst_underflow", underflow, 0);
    check("rst_ram_en", ram_en, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_wdata", ram_wdata, 0);
    check("rst_wr_ready", wr_ready, 0);
    init_mem = 1'b1;
    @(posedge clk); #1;
    init_mem = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    @(posedge clk); #1;

    // Frame start: reads 0..3 back to back, then the port goes idle
    frame_start = 1'b1;
    to_neg();
    check("fs_wr_ready", wr_ready, 0);
    check("fs_no_read", ram_en, 0);
    to_pos();
    frame_start = 1'b0;
    rd_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      to_neg();
      check("pf_ram_en", ram_en, 1);
      check("pf_ram_we", ram_we, 0);
      check("pf_ram_addr", ram_addr, i);
      to_pos();
    end
    to_neg();
    check("pf_full_idle", ram_en, 0);
    to_pos();
    repeat (4) cyc();

    // Line 1 plain, line 2 with a saturating writer
    line(0, 1'b0);
    cyc();
    check("pix_zero_no_de", pix_data, 0);
    check("line1_underflow", underflow, 0);
    repeat (7) cyc();
    wr_before = wr_cnt;
    line(H, 1'b1);
    check("wr_share_3of4", ((wr_cnt - wr_before) >= 356) && ((wr_cnt - wr_before) <= 364), 1);
    check("wr_mem_first", mem[WBASE], {48'hBEEF_0000_0000, 16'd0});
    check("wr_mem_100", mem[WBASE + 15'd100], {48'hBEEF_0000_0000, 16'd100});
    for (int l = 2; l < V; l++) begin
      repeat (8) cyc();
      line(l * H, 1'b0);
    end
    check("frame_underflow", underflow, 0);
    check("last_read_addr", last_rd, LAST);
    check("frame_read_count", rd_cnt, LAST + 1);

    // After prefetch completes the writer owns every cycle
    repeat (4) cyc();
    wr_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      to_neg();
      check("post_wr_en", ram_en, 1);
      check("post_wr_we", ram_we, 1);
      to_pos();
      next_write();
    end
    wr_valid = 1'b0;
    to_neg();
    check("post_idle", ram_en, 0);
    to_pos();

    // Flush with a read in flight and two words buffered
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      to_neg();
      check("restart_en", ram_en && !ram_we, 1);
      check("restart_addr", ram_addr, i);
      to_pos();
    end
    frame_start = 1'b1;
    wr_valid    = 1'b1;
    poke_en     = 1'b1;
    to_neg();
    check("flush_wr_ready", wr_ready, 0);
    check("flush_ram_en", ram_en, 0);
    to_pos();
    frame_start = 1'b0;
    wr_valid    = 1'b0;
    poke_en     = 1'b0;
    repeat (9) cyc();
    for (int i = 0; i < 8; i++) begin
      de = 1'b1;
      exp_q.push_back((i < 4) ? 16'h5555 : 16'h6666);
      cyc();
    end
    de = 1'b0;
    cyc();
    check("flush_underflow", underflow, 0);

    // DE one cycle after frame_start: empty FIFO
    repeat (4) cyc();
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
    de = 1'b1;
    exp_q.push_back(16'd0);
    cyc();
    de = 1'b0;
    check("uf_set", underflow, 1);
    repeat (6) cyc();
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
    repeat (9) cyc();
    for (int i = 0; i < 4; i++) begin
      de = 1'b1;
      exp_q.push_back(16'h5555);
      cyc();
    end
    de = 1'b0;
    cyc();
    check("uf_sticky", underflow, 1);
    check("sb_drained", exp_q.size(), 0);

    nrst = 1'b0;
    #1;
    check("uf_cleared_rst", underflow, 0);
    check("rst2_pix_data", pix_data, 0);
    check("rst2_wr_ready", wr_ready, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lcd_fb_arbiter.md
Name: lcd_fb_arbiter

Overview:
- Shares one single-port framebuffer RAM (64-bit words, 4 RGB565 pixels per word) between LCD scanout prefetch and a pixel writer (drawing engine).
- Scanout always has priority. Write traffic uses the leftover slots, about 3 of every 4 cycles during active video and all cycles when the FIFO is full.
- Sits between the framebuffer RAM and the lcd timing block. It supplies 16-bit pixels in step with the lcd block's DE.

Parameters:
- H_ACTIVE, 480, active pixels per line.
- V_ACTIVE, 272, active lines per frame.
- ADDR_W, 15, RAM word-address width. Must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE/4.
- FIFO_DEPTH, 4, prefetch FIFO depth in words. Power of two, at least 2.

Ports:
- PixelClk  in  1  pixel clock; every register runs on it.
- nRST  in  1  asynchronous, active-low reset.
- frame_start  in  1  one-cycle pulse from the lcd block during vertical blanking, before the first DE of a frame.
- de  in  1  active-pixel strobe from the lcd block; one pixel is consumed per cycle while high.
- pix_data  out  16  RGB565 pixel, registered: the value sampled at the de edge appears the next cycle.
- underflow  out  1  sticky flag: de was high while the FIFO was empty.
- wr_valid  in  1  write request.
- wr_ready  out  1  write accepted this cycle when wr_valid && wr_ready.
- wr_addr  in  ADDR_W  write word address.
- wr_data  in  64  write word. Lane k (pixel k) occupies bits 16k+15:16k.
- ram_en  out  1  RAM access enable.
- ram_we  out  1  RAM write enable; valid only with ram_en.
- ram_addr  out  ADDR_W  RAM word address.
- ram_wdata  out  64  RAM write data.
- ram_rdata  in  64  RAM read data, valid exactly 1 cycle after a read (ram_en=1, ram_we=0).

Behaviour:
- Reset values: pix_data=0, underflow=0, ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0, wr_ready=0.
- Reset also clears internal state: FIFO empty, in-flight flag=0, rd_ptr=0, lane=0, frame_done=1, so prefetch waits for the first frame_start.
- Frame geometry: LAST_WORD = H_ACTIVE*V_ACTIVE/4 - 1 (32639 at defaults).
- The RAM port is driven combinationally from registered state plus wr_* inputs.
- Scan request: scan_req = !frame_done && (fifo_count + inflight < FIFO_DEPTH).
- If scan_req is set:
  - ram_en=1, ram_we=0, ram_addr=rd_ptr; inflight<=1.
  - If rd_ptr==LAST_WORD, then frame_done<=1; otherwise rd_ptr<=rd_ptr+1.
- Writes:
  - wr_ready = !scan_req && !frame_start. It depends on registered state and frame_start only, never on wr_valid.
  - On accept: ram_en=1, ram_we=1, ram_addr=wr_addr, ram_wdata=wr_data.
- Read return: the cycle after a read, ram_rdata is pushed into the FIFO and inflight clears. The space check guarantees the FIFO never overflows.
- Pixel consumption is evaluated each cycle with de=1:
  - FIFO non-empty: pix_data <= head[16*lane+15:16*lane]. Lane increments; at lane==3 the head is popped and lane wraps to 0.
  - FIFO empty: pix_data <= 0, underflow <= 1, lane unchanged.
  - de=0: pix_data <= 0.
- A push and a pop in the same cycle are both performed; the count is unchanged.
- frame_start (highest priority, synchronous):
  - Clears the FIFO, lane, rd_ptr and frame_done. No prefetch issues in the frame_start cycle itself; prefetch starts the next cycle.
  - Read data returning in the frame_start cycle or the cycle after is discarded: an in-flight read at frame_start is dropped.
  - An accepted write is never dropped. wr_ready=0 during frame_start, so no write is accepted in that cycle.
- frame_start arriving while de=1 is a protocol error. It still flushes, and pix_data follows the empty-FIFO rule.
- underflow clears only on reset.
- When the next frame_start arrives with frame_done=1, the writer has had full RAM access between prefetch completion and that pulse.

Test Plan:
- Reset, then frame_start, wr_valid held 0 -> reads at addresses 0,1,2,3 on consecutive cycles; ram_en drops once 4 words are buffered or in flight.
- RAM preloaded with word n = {4{n[15:0]}} -> frame_start, wait 10 cycles, de high for 480 cycles -> pix_data one cycle later shows 0,0,0,0,1,1,1,1,… through 119, with underflow=0.
- wr_valid held 1 during an active line -> writes accepted in every cycle with scan_req=0 (3 of 4 at steady state). Never ram_we with a read in the same cycle, and wr_ready never high while scan_req=1.
- de asserted 1 cycle after frame_start -> pix_data=0 and underflow=1 and stays 1 through later frames until nRST.
- Full frame of 272×480 DE cycles -> last read address is 32639, then ram_en only for writes until the next frame_start. After that pulse, reads restart at address 0.
- frame_start pulsed while a read is in flight and 2 words are buffered -> FIFO empties, the stale ram_rdata is discarded, the first pixel after the next DE comes from word 0, and wr_ready=0 in the pulse cycle.
